// File: rtl/booth_mul_scheduler.sv
// booth_mul_scheduler: round-robin sharing of one registered Booth multiplier among N_REQ requesters
module booth_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_result,
    output logic                   rsp_err,
    output logic                   spurious
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t          state;
    logic [ID_W-1:0] rr, id, gnt, k;
    logic [CW-1:0]   cnt;
    logic            any;
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
    // first valid requester at or above rr, wrapping
    always_comb begin
        gnt = '0;
        any = 1'b0;
        k   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            k = ID_W'((int'(rr) + j) % N_REQ);
            if (!any && req_valid[k]) begin
                any = 1'b1;
                gnt = k;
            end
        end
    end
    assign req_ready = (reset && state == IDLE && any) ? (N_REQ'(1) << gnt) : '0;
    assign rsp_id    = id;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= '0;
            id         <= '0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (mul_done && state != WAIT) spurious <= 1'b1;
            case (state)
                IDLE: if (any) begin
                    mul_a     <= a_arr[gnt];
                    mul_b     <= b_arr[gnt];
                    id        <= gnt;
                    mul_start <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done || cnt == CW'(TIMEOUT - 1)) begin
                        rsp_result <= mul_done ? mul_result : '0;
                        rsp_err    <= !mul_done;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr        <= (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
